// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 serial joystick link: frame size, button bit map, wire polarity.
package joy_db15_pkg;

  localparam int DB15_FRAME_BITS = 32;

  localparam int JOY_BIT_R      = 0;
  localparam int JOY_BIT_L      = 1;
  localparam int JOY_BIT_D      = 2;
  localparam int JOY_BIT_U      = 3;
  localparam int JOY_BIT_A      = 4;
  localparam int JOY_BIT_B      = 5;
  localparam int JOY_BIT_C      = 6;
  localparam int JOY_BIT_D_BTN  = 7;
  localparam int JOY_BIT_E      = 8;
  localparam int JOY_BIT_F      = 9;
  localparam int JOY_BIT_START  = 10;
  localparam int JOY_BIT_SELECT = 11;

  // Level a pressed button shows on JOY_DATA.
  localparam logic DB15_PRESSED_LVL = 1'b0;

  function automatic logic [31:0] db15_wire_word(input logic [15:0] j1, input logic [15:0] j2);
    return (DB15_PRESSED_LVL == 1'b1) ? {j2, j1} : ~{j2, j1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// Serial pins between the user-port master and the DB15 target: load/clock in, data out.
interface joy_db15_tx_if;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
  modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered history for rise/fall pulses.
// Level appears 2 clk after the pin; edge pulses last one clk.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Target side of the DB15 joystick adapter: 74HC165-style shift chain of two joystick words.
// JOY_DATA follows a pin edge within 3 clk; frame_done pulses once per frame; link_active tracks LOAD activity.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int FRAME_BITS  = DB15_FRAME_BITS,
  parameter int TIMEOUT_CYC = 480000
) (
  input  logic                I_CLK_48M,
  input  logic                I_RESETn,
  joy_db15_tx_if.slave        joy,
  input  logic [15:0]         joystick1,
  input  logic [15:0]         joystick2,
  output logic                frame_done,
  output logic                link_active
);

  localparam int              CNT_W   = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [19:0]     TMO_MAX = 20'(TIMEOUT_CYC);

  logic clk_lvl, clk_rise, clk_fall;
  logic load_lvl, load_rise, load_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk   (I_CLK_48M),
    .rst_n (I_RESETn),
    .din   (joy.JOY_CLK),
    .lvl   (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_load (
    .clk   (I_CLK_48M),
    .rst_n (I_RESETn),
    .din   (joy.JOY_LOAD),
    .lvl   (load_lvl),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, clk_lvl, clk_fall, load_rise};

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic [19:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  seen_q, seen_d;
  logic                  link_active_q, link_active_d;

  // Load holds priority over shift, so a clock edge during LOAD low is dropped.
  always_comb begin
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (!load_lvl) begin
      sr_d      = FRAME_BITS'(db15_wire_word(joystick1, joystick2));
      bit_cnt_d = '0;
    end else if (clk_rise) begin
      sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
      if (bit_cnt_q != CNT_FULL) begin
        bit_cnt_d    = bit_cnt_q + 1'b1;
        frame_done_d = (bit_cnt_q == CNT_FULL - 1'b1);
      end
    end
  end

  // seen_q keeps link_active low between reset and the first LOAD fall.
  always_comb begin
    seen_d    = seen_q | load_fall;
    tmo_cnt_d = tmo_cnt_q;
    if (load_fall) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    link_active_d = seen_d && (tmo_cnt_d != TMO_MAX);
  end

  always_ff @(posedge I_CLK_48M) begin
    if (!I_RESETn) begin
      sr_q          <= '1;
      bit_cnt_q     <= CNT_FULL;
      frame_done_q  <= 1'b0;
      tmo_cnt_q     <= '0;
      seen_q        <= 1'b0;
      link_active_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_done_q  <= frame_done_d;
      tmo_cnt_q     <= tmo_cnt_d;
      seen_q        <= seen_d;
      link_active_q <= link_active_d;
    end
  end

  assign joy.JOY_DATA = sr_q[0];
  assign frame_done   = frame_done_q;
  assign link_active  = link_active_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Randomised bench for joy_db15_tx; expected serial bits come from a queue built from the joystick words.
module tb_joy_db15_tx;
  import joy_db15_pkg::*;

  localparam int TMO = 1500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] j1, j2;
  logic        frame_done, link_active;
  int          n_checks = 0;
  int          n_errors = 0;
  int          fd_cnt = 0;
  logic        exp_bits[$];

  joy_db15_tx_if jif ();

  joy_db15_tx #(.FRAME_BITS(32), .TIMEOUT_CYC(TMO)) dut (
    .I_CLK_48M   (clk),
    .I_RESETn    (rst_n),
    .joy         (jif),
    .joystick1   (j1),
    .joystick2   (j2),
    .frame_done  (frame_done),
    .link_active (link_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master view: after a load, bit k is driven low iff that button is pressed; 1s follow the frame.
  task automatic model_load(input logic [15:0] a, input logic [15:0] b);
    exp_bits.delete();
    for (int i = 0; i < 16; i++) exp_bits.push_back(!a[i]);
    for (int i = 0; i < 16; i++) exp_bits.push_back(!b[i]);
  endtask

  function automatic logic model_next();
    return (exp_bits.size() > 0) ? exp_bits[0] : 1'b1;
  endfunction

  task automatic do_load(input logic [15:0] a, input logic [15:0] b, input int hold);
    j1 = a;
    j2 = b;
    jif.JOY_LOAD = 1'b0;
    wait_clk(hold);
    jif.JOY_LOAD = 1'b1;
    wait_clk(6);
    model_load(a, b);
  endtask

  task automatic pulse();
    jif.JOY_CLK = 1'b1;
    wait_clk($urandom_range(5, 9));
    jif.JOY_CLK = 1'b0;
    wait_clk($urandom_range(5, 9));
    if (exp_bits.size() > 0) void'(exp_bits.pop_front());
  endtask

  task automatic shift_bits(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, jif.JOY_DATA}, {31'd0, model_next()});
      pulse();
    end
  endtask

  task automatic full_frame(input string tag);
    int fd0;
    fd0 = fd_cnt;
    shift_bits(tag, 31);
    chk({tag, "_fd_early"}, fd_cnt - fd0, 0);
    shift_bits({tag, "_last"}, 1);
    chk({tag, "_fd_once"}, fd_cnt - fd0, 1);
    chk({tag, "_tail"}, {31'd0, jif.JOY_DATA}, 1);
  endtask

  initial begin
    int fd0;
    int cyc;
    logic [15:0] r1, r2;

    rst_n = 1'b0;
    jif.JOY_CLK = 1'b0;
    jif.JOY_LOAD = 1'b1;
    j1 = '0;
    j2 = '0;
    for (int i = 0; i < 3; i++) begin
      jif.JOY_CLK = ~jif.JOY_CLK;
      @(negedge clk);
      chk("rst_data", {31'd0, jif.JOY_DATA}, 1);
      chk("rst_fd", {31'd0, frame_done}, 0);
      chk("rst_link", {31'd0, link_active}, 0);
    end
    jif.JOY_CLK = 1'b0;
    rst_n = 1'b1;
    wait_clk(6);
    chk("post_rst_data", {31'd0, jif.JOY_DATA}, 1);
    chk("post_rst_link", {31'd0, link_active}, 0);

    do_load(16'h0005, 16'h8000, 10);
    chk("link_up", {31'd0, link_active}, 1);
    full_frame("fixed");

    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk("over_data", {31'd0, jif.JOY_DATA}, 1);
    end
    chk("over_fd", fd_cnt - fd0, 0);

    for (int f = 0; f < 4; f++) begin
      r1 = 16'($urandom);
      r2 = 16'($urandom);
      do_load(r1, r2, $urandom_range(3, 12));
      chk("rand_link", {31'd0, link_active}, 1);
      full_frame($sformatf("rand%0d", f));
    end

    // Clock edge arrives while LOAD is held low: it must not consume a bit.
    r1 = 16'($urandom);
    r2 = 16'($urandom);
    j1 = r1;
    j2 = r2;
    jif.JOY_LOAD = 1'b0;
    wait_clk(5);
    jif.JOY_CLK = 1'b1;
    wait_clk(6);
    jif.JOY_CLK = 1'b0;
    wait_clk(6);
    chk("prio_in_load", {31'd0, jif.JOY_DATA}, {31'd0, !r1[JOY_BIT_R]});
    jif.JOY_LOAD = 1'b1;
    wait_clk(6);
    model_load(r1, r2);
    chk("prio_after", {31'd0, jif.JOY_DATA}, {31'd0, !r1[JOY_BIT_R]});
    full_frame("prio");

    jif.JOY_LOAD = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 6; i++) begin
      j1 = 16'($urandom);
      j1[JOY_BIT_R] = i[0];
      @(negedge clk);
      chk("transp", {31'd0, jif.JOY_DATA}, {31'd0, !j1[JOY_BIT_R]});
    end
    jif.JOY_LOAD = 1'b1;
    wait_clk(6);
    model_load(j1, j2);
    full_frame("transp");

    do_load(16'($urandom), 16'($urandom), 8);
    shift_bits("midrst", 10);
    fd0 = fd_cnt;
    rst_n = 1'b0;
    wait_clk(2);
    chk("midrst_data", {31'd0, jif.JOY_DATA}, 1);
    chk("midrst_link", {31'd0, link_active}, 0);
    rst_n = 1'b1;
    exp_bits.delete();
    for (int i = 0; i < 25; i++) begin
      pulse();
      chk("midrst_idle", {31'd0, jif.JOY_DATA}, 1);
    end
    chk("midrst_fd", fd_cnt - fd0, 0);
    do_load(16'($urandom), 16'($urandom), 10);
    full_frame("after_rst");

    // Let the link lapse, then time one full timeout window from a single LOAD fall.
    cyc = 0;
    while (link_active !== 1'b0 && cyc < TMO + 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_lapse", {31'd0, link_active}, 0);
    jif.JOY_LOAD = 1'b0;
    cyc = 0;
    while (link_active !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    jif.JOY_LOAD = 1'b1;
    chk("tmo_rise", {31'd0, link_active}, 1);
    cyc = 0;
    while (link_active === 1'b1 && cyc < TMO + 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_len", cyc, TMO);
    wait_clk(20);
    chk("tmo_stay_low", {31'd0, link_active}, 0);
    jif.JOY_LOAD = 1'b0;
    wait_clk(5);
    jif.JOY_LOAD = 1'b1;
    chk("tmo_restore", {31'd0, link_active}, 1);
    wait_clk(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
